mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised memory access sequencer for the multi-cycle CPU. It arbitrates NUM_CH requesters, such as instruction fetch and data access, onto the single shared memory bus (readM, writeM, address, bidirectional data) with a fixed memory latency. It returns read data and a one-cycle completion pulse to the granted channel. It replaces ad-hoc bus driving in the datapath and makes the channel count, word widths and latency configurable.

Parameters:
WORD_W, 16, data word width
ADDR_W, 16, address width
NUM_CH, 2, number of requesting channels (>=1); channel 0 = instruction fetch by convention
LATENCY, 2, cycles readM/writeM are held before data is valid or the write completes (>=1)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_CH  per-channel request level; held until done
we  input  NUM_CH  per-channel write enable (1=write, 0=read), sampled at grant
req_addr  input  NUM_CH*ADDR_W  packed per-channel address, channel i at bits [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_CH*WORD_W  packed per-channel write data
done  output  NUM_CH  one-cycle completion pulse to the granted channel
rdata  output  WORD_W  last read data, stable until the next read completes
busy  output  1  high in ACCESS and DONE
readM  output  1  memory read strobe
writeM  output  1  memory write strobe
address  output  ADDR_W  memory address
data  inout  WORD_W  memory data bus; driven only while writeM=1, else high-Z

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: state=IDLE; readM=0; writeM=0; address=0; data=Z; done=0; rdata=0; busy=0; rr_ptr=NUM_CH-1, so channel 0 wins the first grant.
- All outputs are registered except data. data is a tri-state driver of the latched wdata, gated by writeM.
- FSM IDLE:
  - No req bit set: stay in IDLE.
  - Otherwise grant by round-robin. Search starts at channel rr_ptr+1, wraps modulo NUM_CH, first set bit wins.
  - Latch ch, we[ch], addr[ch] and wdata[ch]. Set rr_ptr=ch and cnt=LATENCY-1.
  - Assert readM (we=0) or writeM (we=1), drive address, go to ACCESS.
- FSM ACCESS:
  - Strobes and address are held constant.
  - cnt!=0: decrement cnt.
  - cnt==0: on a read, capture data into rdata. Deassert strobes, set done[ch]=1, go to DONE.
- FSM DONE: done[ch] is high for exactly this cycle, then clear it and go to IDLE.
- Strobe timing: strobes are asserted for exactly LATENCY cycles, starting the cycle after the grant edge.
- Latency and throughput:
  - Request seen in IDLE to done pulse: LATENCY+1 cycles.
  - Back-to-back throughput: one access per LATENCY+2 cycles.
- Requester contract:
  - req, we, addr and wdata are sampled only at grant. Later changes are ignored.
  - The requester clears req on the edge ending done. A req still high in the following IDLE cycle is a new request.
- Request dropped mid-access: the access completes normally and done still pulses.
- Simultaneous requests: round-robin guarantees no channel waits more than NUM_CH-1 accesses.
- readM and writeM are never high together.
- NUM_CH=1: arbitration degenerates to always granting channel 0.
- Reset mid-operation: strobes drop and data goes Z immediately (asynchronous). The pending access is discarded with no done pulse. rr_ptr returns to NUM_CH-1.
- rdata is unchanged by write accesses.

Optional Feature:
MEM_ACCESS_STATS_EN:
- Defined: adds output access_cnt (WORD_W), a count of completed accesses. It increments on every DONE cycle, saturates at all-ones and resets to 0. It feeds the CPU's num_inst-style debug reporting.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- LATENCY=2, NUM_CH=2. Reset, then req=01, we=0, addr0=0x0010, memory returns 0x1234. Required: readM high for 2 cycles with address=0x0010; done=01 for one cycle; rdata=0x1234; busy low afterwards.
- Write: req=10, we=10, addr1=0x0020, wdata1=0xBEEF. Required: writeM high for 2 cycles; data=0xBEEF only during writeM, Z otherwise; memory[0x20]=0xBEEF; rdata unchanged.
- Both channels request continuously, 4 accesses. Required: grant order 0,1,0,1; each done pulse one cycle wide; accesses spaced 4 cycles apart.
- reset_n low during the 2nd ACCESS cycle of a read. Required: readM drops asynchronously, no done pulse, all outputs at reset values; the next request goes to channel 0.
- addr0 changed from 0x0010 to 0x0099 mid-access. Required: address stays 0x0010 until done.
- With MEM_ACCESS_STATS_EN defined, 3 accesses completed. Required: access_cnt=3; reset returns it to 0.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_access_unit                                            |
// | Description : Memory access sequencer for the multi-cycle CPU. Grants    |
// |               one of NUM_CH requesters at a time, round-robin, onto the  |
// |               shared memory bus. readM/writeM are held for LATENCY       |
// |               cycles, then done pulses for one cycle on the granted      |
// |               channel.                                                   |
// | Ports       : clk, reset_n          clock / async active-low reset       |
// |               req, we               per-channel request / write enable   |
// |               req_addr, req_wdata   packed per-channel address / data    |
// |               done                  one-cycle completion pulse           |
// |               rdata                 last read data                       |
// |               busy                  high in ACCESS and DONE              |
// |               readM, writeM,        memory bus strobes, address and      |
// |               address, data         bidirectional data                   |
// |               access_cnt            completed accesses (optional)        |
// | Options     : MEM_ACCESS_STATS_EN adds the access_cnt output/counter.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
   parameter int WORD_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int NUM_CH  = 2,
   parameter int LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*WORD_W-1:0] req_wdata,
   output logic [NUM_CH-1:0]        done,
   output logic [WORD_W-1:0]        rdata,
   output logic                     busy,
   output logic                     readM,
   output logic                     writeM,
   output logic [ADDR_W-1:0]        address,
   inout  wire  [WORD_W-1:0]        data
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [WORD_W-1:0]        access_cnt
`endif
);

   localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CH_W-1:0]  C_LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Registered state
   state_t             r_state;
   logic [CH_W-1:0]    r_ch;
   logic [CH_W-1:0]    r_rr_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic [WORD_W-1:0]  r_wdata;
   logic [ADDR_W-1:0]  r_addr;
   logic [WORD_W-1:0]  r_rdata;
   logic [NUM_CH-1:0]  r_done;
   logic               r_busy;
   logic               r_readM;
   logic               r_writeM;

   // Next-state values
   state_t             w_state_nxt;
   logic [CH_W-1:0]    w_ch_nxt;
   logic [CH_W-1:0]    w_rr_ptr_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [WORD_W-1:0]  w_wdata_nxt;
   logic [ADDR_W-1:0]  w_addr_nxt;
   logic [WORD_W-1:0]  w_rdata_nxt;
   logic [NUM_CH-1:0]  w_done_nxt;
   logic               w_busy_nxt;
   logic               w_readM_nxt;
   logic               w_writeM_nxt;

   // Round-robin arbiter
   logic               w_grant_vld;
   logic [CH_W-1:0]    w_grant_ch;
   int                 w_idx;

   // Search begins one past the last granted channel and wraps, so the
   // most recently served channel has the lowest priority.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_ch  = '0;
      w_idx       = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         w_idx = int'(r_rr_ptr) + i;
         if (w_idx >= NUM_CH) begin
            w_idx = w_idx - NUM_CH;
         end
         if (!w_grant_vld && req[w_idx]) begin
            w_grant_vld = 1'b1;
            w_grant_ch  = CH_W'(w_idx);
         end
      end
   end

   // Next-state and output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_ch_nxt     = r_ch;
      w_rr_ptr_nxt = r_rr_ptr;
      w_cnt_nxt    = r_cnt;
      w_wdata_nxt  = r_wdata;
      w_addr_nxt   = r_addr;
      w_rdata_nxt  = r_rdata;
      w_done_nxt   = '0;
      w_busy_nxt   = r_busy;
      w_readM_nxt  = r_readM;
      w_writeM_nxt = r_writeM;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_vld) begin
               w_ch_nxt     = w_grant_ch;
               w_rr_ptr_nxt = w_grant_ch;
               w_cnt_nxt    = C_CNT_INIT;
               w_addr_nxt   = req_addr[w_grant_ch*ADDR_W +: ADDR_W];
               w_wdata_nxt  = req_wdata[w_grant_ch*WORD_W +: WORD_W];
               w_readM_nxt  = !we[w_grant_ch];
               w_writeM_nxt = we[w_grant_ch];
               w_busy_nxt   = 1'b1;
               w_state_nxt  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               if (r_readM) begin
                  w_rdata_nxt = data;
               end
               w_readM_nxt      = 1'b0;
               w_writeM_nxt     = 1'b0;
               w_done_nxt[r_ch] = 1'b1;
               w_state_nxt      = ST_DONE;
            end
         end
         ST_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_readM_nxt  = 1'b0;
            w_writeM_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_ch     <= '0;
         r_rr_ptr <= C_LAST_CH;
         r_cnt    <= '0;
         r_wdata  <= '0;
         r_addr   <= '0;
         r_rdata  <= '0;
         r_done   <= '0;
         r_busy   <= 1'b0;
         r_readM  <= 1'b0;
         r_writeM <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ch     <= w_ch_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_wdata  <= w_wdata_nxt;
         r_addr   <= w_addr_nxt;
         r_rdata  <= w_rdata_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= w_busy_nxt;
         r_readM  <= w_readM_nxt;
         r_writeM <= w_writeM_nxt;
      end
   end

   assign done    = r_done;
   assign rdata   = r_rdata;
   assign busy    = r_busy;
   assign readM   = r_readM;
   assign writeM  = r_writeM;
   assign address = r_addr;

   // Only drive the shared bus while a write strobe is active.
   assign data = r_writeM ? r_wdata : {WORD_W{1'bz}};

`ifdef MEM_ACCESS_STATS_EN
   logic [WORD_W-1:0] r_access_cnt;

   // Saturating count of completed accesses; one per DONE cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_access_cnt <= '0;
      end else if ((r_state == ST_DONE) && (r_access_cnt != '1)) begin
         r_access_cnt <= r_access_cnt + 1'b1;
      end
   end

   assign access_cnt = r_access_cnt;
`else
   // No statistics counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                         |
// | Description : Directed self-checking bench for mem_access_unit with      |
// |               LATENCY=2, NUM_CH=2 and a small memory model on the bus.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

   localparam int WORD_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int NUM_CH  = 2;
   localparam int LATENCY = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        req;
   logic [1:0]        we;
   logic [15:0]       addr0, addr1, wdata0, wdata1;
   wire  [31:0]       req_addr  = {addr1, addr0};
   wire  [31:0]       req_wdata = {wdata1, wdata0};
   logic [1:0]        done;
   logic [15:0]       rdata;
   logic              busy, readM, writeM;
   logic [15:0]       address;
   wire  [15:0]       data;
`ifdef MEM_ACCESS_STATS_EN
   logic [15:0]       access_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   mem_access_unit #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W),
      .NUM_CH (NUM_CH),
      .LATENCY(LATENCY)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .we        (we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .done      (done),
      .rdata     (rdata),
      .busy      (busy),
      .readM     (readM),
      .writeM    (writeM),
      .address   (address),
      .data      (data)
`ifdef MEM_ACCESS_STATS_EN
      ,
      .access_cnt(access_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Read-only memory contents seen on the bus during readM.
   function automatic logic [15:0] mem_val(input logic [15:0] a);
      case (a)
         16'h0010: mem_val = 16'h1234;
         16'h0030: mem_val = 16'hA0A0;
         16'h0031: mem_val = 16'hB1B1;
         16'h0040: mem_val = 16'h5A5A;
         default:  mem_val = 16'h0000;
      endcase
   endfunction

   assign data = readM ? mem_val(address) : 16'bz;

   // Last write seen by memory.
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   always @(posedge clk) begin
      if (writeM) begin
         wr_addr <= address;
         wr_data <= data;
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      req = '0; we = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({readM, writeM, busy, done, address, rdata} !== 37'd0) begin
         n_err++;
         $display("FAIL reset_state: got rM=%b wM=%b busy=%b done=%b addr=%h rdata=%h, want all 0",
                  readM, writeM, busy, done, address, rdata);
      end
   endtask

   task automatic test_read();
      req = 2'b01; we = 2'b00; addr0 = 16'h0010;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({readM, writeM, busy, done, address} !== {3'b101, 2'b00, 16'h0010}) begin
            n_err++;
            $display("FAIL read_strobe[%0d]: got rM=%b wM=%b busy=%b done=%b addr=%h, want 1 0 1 00 0010",
                     c, readM, writeM, busy, done, address);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({readM, writeM, busy, done, rdata} !== {3'b001, 2'b01, 16'h1234}) begin
         n_err++;
         $display("FAIL read_done: got rM=%b wM=%b busy=%b done=%b rdata=%h, want 0 0 1 01 1234",
                  readM, writeM, busy, done, rdata);
      end
      req = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 3'b000) begin
         n_err++;
         $display("FAIL read_idle: got busy=%b done=%b, want 0 00", busy, done);
      end
   endtask

   task automatic test_addr_hold();
      req = 2'b01; we = 2'b00; addr0 = 16'h0010;
      @(negedge clk);
      addr0 = 16'h0099;
      @(negedge clk);
      n_cmp++;
      if ({readM, address} !== {1'b1, 16'h0010}) begin
         n_err++;
         $display("FAIL addr_hold: got rM=%b addr=%h, want 1 0010", readM, address);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, address, rdata} !== {2'b01, 16'h0010, 16'h1234}) begin
         n_err++;
         $display("FAIL addr_hold_done: got done=%b addr=%h rdata=%h, want 01 0010 1234",
                  done, address, rdata);
      end
      req = 2'b00; addr0 = 16'h0010;
      @(negedge clk);
   endtask

   task automatic test_write();
      req = 2'b10; we = 2'b10; addr1 = 16'h0020; wdata1 = 16'hBEEF;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({readM, writeM, address, data} !== {2'b01, 16'h0020, 16'hBEEF}) begin
            n_err++;
            $display("FAIL write_strobe[%0d]: got rM=%b wM=%b addr=%h data=%h, want 0 1 0020 BEEF",
                     c, readM, writeM, address, data);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({writeM, done, rdata, wr_addr, wr_data} !== {1'b0, 2'b10, 16'h1234, 16'h0020, 16'hBEEF}) begin
         n_err++;
         $display("FAIL write_done: got wM=%b done=%b rdata=%h mem[%h]=%h, want 0 10 1234 mem[0020]=BEEF",
                  writeM, done, rdata, wr_addr, wr_data);
      end
      req = 2'b00; we = 2'b00;
      @(negedge clk);
      // Read on channel 1 afterwards: memory must own the bus during readM.
      req = 2'b10; addr1 = 16'h0040;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({done, rdata} !== {2'b10, 16'h5A5A}) begin
         n_err++;
         $display("FAIL read_after_write: got done=%b rdata=%h, want 10 5A5A", done, rdata);
      end
      req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int got    = 0;
      int last_t = 0;
      logic [1:0]  exp_done;
      logic [15:0] exp_rdata;
      addr0 = 16'h0030; addr1 = 16'h0031; we = 2'b00; req = 2'b11;
      for (int t = 0; t < 40 && got < 4; t++) begin
         @(negedge clk);
         if (done != 2'b00) begin
            exp_done  = (got % 2 == 0) ? 2'b01 : 2'b10;
            exp_rdata = (got % 2 == 0) ? 16'hA0A0 : 16'hB1B1;
            n_cmp++;
            if ({done, rdata} !== {exp_done, exp_rdata}) begin
               n_err++;
               $display("FAIL b2b_grant[%0d]: got done=%b rdata=%h, want %b %h",
                        got, done, rdata, exp_done, exp_rdata);
            end
            if (got > 0) begin
               n_cmp++;
               if (t - last_t != 4) begin
                  n_err++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 4", got, t - last_t);
               end
            end
            last_t = t;
            got++;
            if (got == 4) req = 2'b00;
         end
      end
      n_cmp++;
      if (got != 4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d accesses, want 4", got);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 3'b000) begin
         n_err++;
         $display("FAIL b2b_idle: got busy=%b done=%b, want 0 00", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      logic saw_done = 1'b0;
      req = 2'b01; we = 2'b00; addr0 = 16'h0010;
      @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({readM, writeM, busy, done, address, rdata} !== 37'd0) begin
         n_err++;
         $display("FAIL reset_mid_async: got rM=%b wM=%b busy=%b done=%b addr=%h rdata=%h, want all 0",
                  readM, writeM, busy, done, address, rdata);
      end
      req = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done != 2'b00) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_no_done: got a done pulse, want none");
      end
      req = 2'b11; addr0 = 16'h0010; addr1 = 16'h0031;
      @(negedge clk);
      n_cmp++;
      if ({readM, address} !== {1'b1, 16'h0010}) begin
         n_err++;
         $display("FAIL reset_mid_regrant: got rM=%b addr=%h, want 1 0010 (channel 0)", readM, address);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (done !== 2'b01) begin
         n_err++;
         $display("FAIL reset_mid_regrant_done: got done=%b, want 01", done);
      end
      req = 2'b00;
      @(negedge clk);
   endtask

`ifdef MEM_ACCESS_STATS_EN
   task automatic test_stats();
      do_reset();
      n_cmp++;
      if (access_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL stats_reset: got access_cnt=%0d, want 0", access_cnt);
      end
      for (int k = 0; k < 3; k++) begin
         req = 2'b01; we = 2'b00; addr0 = 16'h0010;
         repeat (3) @(negedge clk);
         req = 2'b00;
         @(negedge clk);
      end
      n_cmp++;
      if (access_cnt !== 16'd3) begin
         n_err++;
         $display("FAIL stats_count: got access_cnt=%0d, want 3", access_cnt);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (access_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL stats_clear: got access_cnt=%0d, want 0", access_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      req = '0; we = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      test_reset();
      test_read();
      test_addr_hold();
      test_write();
      test_back_to_back();
      test_reset_mid();
`ifdef MEM_ACCESS_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
